// File: rtl/parallel_stateful_stream_processor.sv
// Folds LANES bytes per accepted beat into an 8-bit running state (sum/xor/max/last)
// and presents one registered result per beat, with a per-frame saturating kept-byte count.
module parallel_stateful_stream_processor #(
    parameter int LANES       = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*LANES-1:0]     in_data,
    input  logic [LANES-1:0]       in_keep,
    input  logic                   in_last,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] out_count
);
    localparam int PW = $clog2(LANES + 1);
    localparam int SW = COUNT_WIDTH + PW;
    localparam logic [SW-1:0] CNT_MAX = {{PW{1'b0}}, {COUNT_WIDTH{1'b1}}};

    logic [7:0]             acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]             frame_mode_q, frame_mode_d;
    logic                   in_frame_q, in_frame_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;

    logic                   accept;
    logic [1:0]             eff_mode;
    logic [7:0]             fold_acc;
    logic [7:0]             lane_byte;
    logic [PW-1:0]          pop;
    logic [SW-1:0]          cnt_sum;
    logic [COUNT_WIDTH-1:0] cnt_new;

    // Ready never looks at in_valid, so upstream may wait on it without a loop.
    assign in_ready = !reset && enable && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign eff_mode = in_frame_q ? frame_mode_q : mode;

    always_comb begin
        fold_acc  = acc_q;
        lane_byte = 8'h00;
        pop       = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_byte = in_data[8*i +: 8];
            if (in_keep[i]) begin
                pop = pop + PW'(1);
                case (eff_mode)
                    2'd0:    fold_acc = fold_acc + lane_byte;
                    2'd1:    fold_acc = fold_acc ^ lane_byte;
                    2'd2:    if (lane_byte > fold_acc) fold_acc = lane_byte;
                    default: fold_acc = lane_byte;
                endcase
            end
        end
        cnt_sum = {{PW{1'b0}}, cnt_q} + SW'(pop);
        cnt_new = (cnt_sum > CNT_MAX) ? CNT_MAX[COUNT_WIDTH-1:0] : cnt_sum[COUNT_WIDTH-1:0];
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        frame_mode_d = frame_mode_q;
        in_frame_d   = in_frame_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_count_d  = out_count_q;
        if (enable) begin
            if (accept) begin
                out_valid_d  = 1'b1;
                out_data_d   = fold_acc;
                out_last_d   = in_last;
                out_count_d  = cnt_new;
                frame_mode_d = eff_mode;
                if (in_last) begin
                    acc_d      = 8'h00;
                    cnt_d      = '0;
                    in_frame_d = 1'b0;
                end else begin
                    acc_d      = fold_acc;
                    cnt_d      = cnt_new;
                    in_frame_d = 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q        <= 8'h00;
            cnt_q        <= '0;
            frame_mode_q <= 2'd0;
            in_frame_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_last_q   <= 1'b0;
            out_count_q  <= '0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            frame_mode_q <= frame_mode_d;
            in_frame_q   <= in_frame_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_count_q  <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_count = out_count_q;
endmodule

// File: tb/tb_parallel_stateful_stream_processor.sv
// Directed scenarios from the block's test plan plus a randomized run against a reference model.
module tb_parallel_stateful_stream_processor;
    logic        clock = 1'b0;
    logic        reset, enable, in_valid, in_last, out_ready;
    logic [23:0] in_data;
    logic [2:0]  in_keep;
    logic [1:0]  mode;
    logic        in_ready, out_valid, out_last;
    logic [7:0]  out_data;
    logic [15:0] out_count;
    logic        in_ready4, out_valid4, out_last4;
    logic [7:0]  out_data4;
    logic [3:0]  out_count4;

    int checks = 0;
    int failures = 0;

    parallel_stateful_stream_processor #(.LANES(3), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_count(out_count));

    // Same stimulus, narrow counter for saturation.
    parallel_stateful_stream_processor #(.LANES(3), .COUNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .mode(mode),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_last(out_last4), .out_count(out_count4));

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model state
    int         m_acc, m_cnt, m_cnt4, m_fmode;
    bit         m_inf, m_ov, m_olast;
    int         m_odata, m_ocnt, m_ocnt4;

    function automatic int ref_fold(int st, logic [23:0] d, logic [2:0] k, logic [1:0] md);
        int kept[$];
        int r;
        for (int i = 0; i < 3; i++)
            if (k[i]) kept.push_back(int'(d[8*i +: 8]));
        r = st;
        foreach (kept[j]) begin
            case (md)
                2'd0: r = (r + kept[j]) % 256;
                2'd1: r = r ^ kept[j];
                2'd2: r = (kept[j] > r) ? kept[j] : r;
                default: r = kept[j];
            endcase
        end
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic beat(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [2:0] k, input logic l, input logic [1:0] m);
        int waited;
        in_data = {b2, b1, b0}; in_keep = k; in_last = l; mode = m; in_valid = 1'b1;
        waited = 0;
        #1;
        while (!in_ready && waited < 20) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL beat_accept_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        in_data = '0; in_keep = '0; in_last = 1'b0; mode = 2'd0;
        @(posedge clock); #1;
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        if (out_count !== 16'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
        if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_sum_frame();
        logic [7:0]  ed[4];
        logic [15:0] ec[4];
        logic        el[4];
        ed = '{8'h60, 8'h51, 8'h05, 8'h05};
        ec = '{16'd3, 16'd5, 16'd1, 16'd1};
        el = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: beat(8'h10, 8'h20, 8'h30, 3'b111, 1'b0, 2'd0);
                1: beat(8'hF0, 8'h01, 8'h00, 3'b011, 1'b1, 2'd0);
                2: beat(8'h05, 8'hAA, 8'hBB, 3'b001, 1'b0, 2'd0);
                default: beat(8'h77, 8'h88, 8'h99, 3'b000, 1'b1, 2'd0);
            endcase
            checks += 4;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL sum_valid beat=%0d got=%0b exp=1", i, out_valid); end
            if (out_data !== ed[i]) begin failures++; $display("FAIL sum_data beat=%0d got=%h exp=%h", i, out_data, ed[i]); end
            if (out_count !== ec[i]) begin failures++; $display("FAIL sum_count beat=%0d got=%0d exp=%0d", i, out_count, ec[i]); end
            if (out_last !== el[i]) begin failures++; $display("FAIL sum_last beat=%0d got=%0b exp=%0b", i, out_last, el[i]); end
        end
    endtask

    task automatic test_mode_latch();
        logic [7:0] ed[3];
        ed = '{8'h90, 8'hA0, 8'h00};
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: beat(8'h07, 8'h90, 8'h22, 3'b111, 1'b0, 2'd2);
                1: beat(8'hA0, 8'h00, 8'h00, 3'b001, 1'b1, 2'd1);
                default: beat(8'h0F, 8'hF0, 8'hFF, 3'b111, 1'b1, 2'd1);
            endcase
            checks++;
            if (out_data !== ed[i]) begin failures++; $display("FAIL mode_latch_data beat=%0d got=%h exp=%h", i, out_data, ed[i]); end
        end
    endtask

    task automatic test_backpressure();
        beat(8'h01, 8'h02, 8'h03, 3'b111, 1'b0, 2'd0);
        out_ready = 1'b0;
        in_data = {8'h06, 8'h05, 8'h04}; in_keep = 3'b111; in_last = 1'b1; in_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks += 4;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%0b exp=1", i, out_valid); end
            if (out_data !== 8'h06) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=06", i, out_data); end
            if (out_count !== 16'd3) begin failures++; $display("FAIL bp_count cyc=%0d got=%0d exp=3", i, out_count); end
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", out_valid); end
        if (out_data !== 8'h15) begin failures++; $display("FAIL b2b_data got=%h exp=15", out_data); end
        if (out_count !== 16'd6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", out_count); end
        if (out_last !== 1'b1) begin failures++; $display("FAIL b2b_last got=%0b exp=1", out_last); end
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL consume_clear got=%0b exp=0", out_valid); end
    endtask

    task automatic test_enable_keep();
        beat(8'h10, 8'h20, 8'h30, 3'b111, 1'b0, 2'd0);
        enable = 1'b0;
        in_data = 24'h010101; in_keep = 3'b000; in_last = 1'b1; in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            checks += 4;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL en_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL en_valid cyc=%0d got=%0b exp=1", i, out_valid); end
            if (out_data !== 8'h60) begin failures++; $display("FAIL en_data cyc=%0d got=%h exp=60", i, out_data); end
            if (out_count !== 16'd3) begin failures++; $display("FAIL en_count cyc=%0d got=%0d exp=3", i, out_count); end
        end
        enable = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL en_resume_ready got=%0b exp=1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks += 3;
        if (out_data !== 8'h60) begin failures++; $display("FAIL keep0_data got=%h exp=60", out_data); end
        if (out_count !== 16'd3) begin failures++; $display("FAIL keep0_count got=%0d exp=3", out_count); end
        if (out_last !== 1'b1) begin failures++; $display("FAIL keep0_last got=%0b exp=1", out_last); end
        beat(8'h05, 8'h00, 8'h00, 3'b001, 1'b1, 2'd0);
        checks += 2;
        if (out_data !== 8'h05) begin failures++; $display("FAIL restart_data got=%h exp=05", out_data); end
        if (out_count !== 16'd1) begin failures++; $display("FAIL restart_count got=%0d exp=1", out_count); end
    endtask

    task automatic test_reset_mid_frame();
        beat(8'h10, 8'h20, 8'h30, 3'b111, 1'b0, 2'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", out_valid); end
        if (out_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", out_data); end
        beat(8'h11, 8'h22, 8'h33, 3'b101, 1'b1, 2'd3);
        checks += 2;
        if (out_data !== 8'h33) begin failures++; $display("FAIL midrst_next_data got=%h exp=33", out_data); end
        if (out_count !== 16'd2) begin failures++; $display("FAIL midrst_next_count got=%0d exp=2", out_count); end
    endtask

    task automatic test_saturation();
        logic [3:0] ec;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            beat(8'h01, 8'h01, 8'h01, 3'b111, 1'b0, 2'd0);
            ec = (3 * k > 15) ? 4'd15 : 4'(3 * k);
            checks += 2;
            if (out_count4 !== ec) begin failures++; $display("FAIL sat_count beat=%0d got=%0d exp=%0d", k, out_count4, ec); end
            if (out_data4 !== 8'(3 * k)) begin failures++; $display("FAIL sat_data beat=%0d got=%h exp=%h", k, out_data4, 8'(3 * k)); end
        end
    endtask

    task automatic test_random();
        bit pending, m_ready, m_acc_now;
        int nc;
        do_reset();
        m_acc = 0; m_cnt = 0; m_cnt4 = 0; m_fmode = 0; m_inf = 0;
        m_ov = 0; m_olast = 0; m_odata = 0; m_ocnt = 0; m_ocnt4 = 0;
        pending = 0;
        for (int c = 0; c < 400; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if (!pending) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_data  = 24'($urandom);
                in_keep  = 3'($urandom_range(0, 7));
                in_last  = ($urandom_range(0, 3) == 0);
                mode     = 2'($urandom_range(0, 3));
            end
            #1;
            m_ready   = enable && (!m_ov || out_ready);
            m_acc_now = in_valid && m_ready;
            checks++;
            if (in_ready !== m_ready) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", c, in_ready, m_ready); end
            if (m_acc_now) begin
                if (!m_inf) m_fmode = int'(mode);
                m_odata = ref_fold(m_acc, in_data, in_keep, 2'(m_fmode));
                nc = $countones(in_keep);
                m_ocnt  = (m_cnt + nc > 65535) ? 65535 : m_cnt + nc;
                m_ocnt4 = (m_cnt4 + nc > 15) ? 15 : m_cnt4 + nc;
                m_olast = in_last;
                m_ov    = 1;
                if (in_last) begin
                    m_acc = 0; m_cnt = 0; m_cnt4 = 0; m_inf = 0;
                end else begin
                    m_acc = m_odata; m_cnt = m_ocnt; m_cnt4 = m_ocnt4; m_inf = 1;
                end
            end else if (enable && m_ov && out_ready) begin
                m_ov = 0;
            end
            pending = in_valid && !m_acc_now;
            @(posedge clock); #1;
            checks++;
            if (out_valid !== m_ov) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", c, out_valid, m_ov); end
            if (m_ov) begin
                checks += 4;
                if (out_data !== 8'(m_odata)) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, out_data, 8'(m_odata)); end
                if (out_count !== 16'(m_ocnt)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, out_count, m_ocnt); end
                if (out_last !== m_olast) begin failures++; $display("FAIL rnd_last cyc=%0d got=%0b exp=%0b", c, out_last, m_olast); end
                if (out_count4 !== 4'(m_ocnt4)) begin failures++; $display("FAIL rnd_count4 cyc=%0d got=%0d exp=%0d", c, out_count4, m_ocnt4); end
            end
        end
        in_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sum_frame();
        test_mode_latch();
        test_backpressure();
        test_enable_keep();
        test_reset_mid_frame();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/parallel_stateful_stream_processor.md
# parallel_stateful_stream_processor

Parametrised successor to the fixed three-byte stateful processor. It folds `LANES` bytes per input beat into an 8-bit running state under a selectable reduction mode. It uses valid/ready handshakes on both sides, per-lane byte enables and frame delimiting. It sits between the board-level byte source and the UART/LED output path, and presents one registered state byte per accepted beat.

## Interface
- `LANES`, default 3: bytes per input beat; must be ≥ 1.
- `COUNT_WIDTH`, default 16: width of the per-frame kept-byte counter; the counter saturates.
- `clock` (in, 1): single clock; all state changes on its rising edge.
- `reset` (in, 1): synchronous, active-high.
- `enable` (in, 1): global run enable; when low the block is frozen.
- `in_valid` (in, 1): input beat present.
- `in_ready` (out, 1): block accepts the beat this cycle.
- `in_data` (in, 8*LANES): lane i occupies bits [8i+7:8i]; lane 0 is the first byte in stream order.
- `in_keep` (in, LANES): bit i=1 means lane i is a real byte.
- `in_last` (in, 1): the beat ends the current frame.
- `mode` (in, 2): reduction select, sampled on the first beat of a frame.
- `out_valid` (out, 1): output register holds an unconsumed result.
- `out_ready` (in, 1): downstream consumes the result.
- `out_data` (out, 8): state after folding the accepted beat.
- `out_last` (out, 1): result belongs to the frame's final beat.
- `out_count` (out, COUNT_WIDTH): kept bytes in the frame up to and including this beat, saturating.

## Operation
- Modes:
  - 0: sum mod 256.
  - 1: XOR.
  - 2: unsigned max.
  - 3: last kept byte.
- Identity state is 0x00 for all modes.
- Internal registers:
  - `acc` (8 bits).
  - `cnt` (COUNT_WIDTH bits).
  - `frame_mode` (2 bits).
  - `in_frame` (1 bit).
- Acceptance condition: `in_valid && in_ready`, with `in_ready = enable && (!out_valid || out_ready)`. This is combinational and has no dependency on `in_valid`.
- On acceptance, determine the effective mode:
  - If `in_frame`=0, use `mode`; also load `frame_mode` and set `in_frame`.
  - Otherwise use `frame_mode`. Changes to `mode` mid-frame are ignored.
- Fold: start from `acc` and apply lanes 0 to LANES-1 in order. Lanes with `in_keep`=0 are skipped. All arithmetic is 8-bit with wrap.
- Count: `cnt + popcount(in_keep)`, clamped to 2^COUNT_WIDTH-1.
- The output register takes the folded value, the new count and `in_last`; `out_valid` is set.
- If `in_last`=1:
  - `acc`←0, `cnt`←0, `in_frame`←0 after the output register is loaded.
  - Otherwise `acc` and `cnt` take the new values.
- All-zero `in_keep`: the beat is still accepted and an output is still produced. `acc` and `cnt` are unchanged. With `in_last`=1 the frame closes normally.
- The output is cleared when `out_valid && out_ready && !(new acceptance)`. With simultaneous consume and accept, the register is reloaded and `out_valid` stays 1.
- `enable`=0:
  - `in_ready`=0.
  - All registers hold, including `out_valid`.
  - `out_ready` is ignored; no consume occurs.

## Timing
- Reset values: `out_valid`=0, `out_data`=0x00, `out_last`=0, `out_count`=0, `in_ready`=0 during the reset cycle. Internally `acc`=0, `cnt`=0, `in_frame`=0, `frame_mode`=0.
- Reset mid-frame discards the partial frame and any pending output. The next accepted beat starts a new frame with the current `mode`.
- Latency is 1 cycle: a beat accepted at edge N appears on `out_*` after edge N.
- Throughput is one beat per cycle while `out_ready`=1 and `enable`=1.
- Handshake:
  - `out_*` is stable while `out_valid && !out_ready`.
  - Upstream must hold `in_*` stable while `in_valid && !in_ready`. The block does not check this.
- Combinational fold depth grows with LANES; it must close at 100 MHz for LANES ≤ 8.

## Test plan
- Sum frame, LANES=3, mode=0:
  - Beat {0x10,0x20,0x30}, keep=111, last=0 → out 0x60, count 3, last 0.
  - Next beat {0xF0,0x01,0x00}, keep=011, last=1 → out 0x51, count 5, last 1.
  - Following frame's first beat {0x05,–,–}, keep=001 → out 0x05, count 1.
- Mode latch:
  - First beat mode=2, {0x07,0x90,0x22} → out 0x90.
  - Second beat mode=1, {0xA0,0x00,0x00}, keep=001, last=1 → out 0xA0 (max retained, XOR ignored).
  - Next frame mode=1, {0x0F,0xF0,0xFF} → out 0x00.
- Backpressure: hold `out_ready`=0 with the output valid → `in_ready`=0; out_data/out_count stable for 5 cycles. Raise `out_ready` together with `in_valid` → the same-cycle consume+accept keeps `out_valid`=1 with the new data.
- Enable/keep:
  - `enable`=0 for 3 cycles with `in_valid`=1 → no acceptance, outputs frozen.
  - keep=000, last=1 → out equals prior acc, count unchanged, last 1; next frame restarts at 0.
- Reset mid-frame: after one sum beat (acc 0x60), pulse reset for 1 cycle → out_valid=0, out_data=0x00. Next beat mode=3, {0x11,0x22,0x33}, keep=101 → out 0x33, count 2.
- Saturation: COUNT_WIDTH=4, mode=0, six full beats of 0x01 without last → out_count 3,6,9,12,15,15; out_data 0x03…0x12.
